// File: rtl/irq_arbiter_pkg.sv
// rtl/irq_arbiter_pkg.sv - shared constants and FSM encoding for irq_arbiter
//
// Purpose: channel count, the encoder "nothing eligible" code and the
//          grant FSM state type, shared by the arbiter and its encoder.
// Ports:   none (package)
package irq_arbiter_pkg;

  localparam int IRQ_CHANNELS = 8;

  // Encoder output with bit 3 set means no input bit was set.
  localparam logic [3:0] IRQ_NONE = 4'h8;

  typedef enum logic [0:0] {
    IRQ_IDLE  = 1'b0,
    IRQ_GRANT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_arbiter_priority_encoder.sv
// rtl/irq_arbiter_priority_encoder.sv - 8-bit combinational priority encoder
//
// Purpose: report the index of the highest set input bit.
// Ports:   in    [7:0] - candidate bits, bit 7 = highest priority
//          index [3:0] - {1'b0, idx} when any bit is set, IRQ_NONE otherwise
module PriorityEncoder
  import irq_arbiter_pkg::*;
(
  input  logic [7:0] in,
  output logic [3:0] index
);

  always_comb begin
    index = IRQ_NONE;
    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < IRQ_CHANNELS; i++) begin
      if (in[i]) begin
        index = {1'b0, i[2:0]};
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - edge-latched, masked interrupt arbiter with acked grant
//
// Purpose: latch rising edges of eight request lines into a pending register,
//          qualify with a mask, pick the highest eligible channel and present
//          it as a registered grant held until the consumer acknowledges it.
// Ports:   clk, reset           - clock, synchronous active-high reset
//          req         [7:0]    - request levels, rising edge posts a request
//          mask_wr, mask_in     - mask register write strobe and data
//          ovf_clr     [7:0]    - write-1-to-clear for overflow bits
//          grant_valid, grant_idx, grant_ack - grant handshake to the host
//          pending, mask, overflow [7:0]     - status registers
module irq_arbiter
  import irq_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic [7:0] ovf_clr,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  input  logic       grant_ack,
  output logic [7:0] pending,
  output logic [7:0] mask,
  output logic [7:0] overflow
);

  irq_state_e state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] overflow_q, overflow_d;
  logic       grant_valid_q, grant_valid_d;
  logic [2:0] grant_idx_q, grant_idx_d;

  logic [7:0] req_edge;
  logic [7:0] grant_clr;
  logic [7:0] ovf_set;
  logic [3:0] enc_index;

  PriorityEncoder u_enc (
    .in    (pending_q & mask_q),
    .index (enc_index)
  );

  always_comb begin
    req_d    = req;
    req_edge = req & ~req_q;

    // One-hot clear of the channel whose grant is being accepted.
    grant_clr = 8'h00;
    if (state_q == IRQ_GRANT && grant_ack) begin
      grant_clr[grant_idx_q] = 1'b1;
    end

    // A fresh edge beats the ack clear; only an edge on a pending bit that
    // is not leaving this cycle counts as a lost request.
    pending_d = (pending_q & ~grant_clr) | req_edge;
    ovf_set   = req_edge & pending_q & ~grant_clr;
    overflow_d = (overflow_q & ~ovf_clr) | ovf_set;

    mask_d = mask_wr ? mask_in : mask_q;
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (!enc_index[3]) begin
          state_d       = IRQ_GRANT;
          grant_valid_d = 1'b1;
          grant_idx_d   = enc_index[2:0];
        end
      end
      IRQ_GRANT: begin
        // No pre-emption: the grant index is frozen until acked.
        if (grant_ack) begin
          state_d       = IRQ_IDLE;
          grant_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = IRQ_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IRQ_IDLE;
      req_q         <= 8'h00;
      pending_q     <= 8'h00;
      mask_q        <= 8'hFF;
      overflow_q    <= 8'h00;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      overflow_q    <= overflow_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pending     = pending_q;
  assign mask        = mask_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed self-checking bench for irq_arbiter
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic [7:0] ovf_clr;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       grant_ack;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .mask_wr     (mask_wr),
    .mask_in     (mask_in),
    .ovf_clr     (ovf_clr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_ack   (grant_ack),
    .pending     (pending),
    .mask        (mask),
    .overflow    (overflow)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'h00; mask_wr = 1'b0; mask_in = 8'h00;
    ovf_clr = 8'h00; grant_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h want 00", pending); end
    n_checks++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL reset_mask got %h want FF", mask); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL reset_overflow got %h want 00", overflow); end
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv got %b want 0", grant_valid); end
    n_checks++; if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", grant_idx); end
  endtask

  task automatic test_single();
    req = 8'h04;
    tick();
    req = 8'h00;
    n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL single_pending got %h want 04", pending); end
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_gv_early got %b want 0", grant_valid); end
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd2) begin n_fail++; $display("FAIL single_grant got gv=%b idx=%0d want gv=1 idx=2", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h00 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack got pend=%h gv=%b want 00/0", pending, grant_valid); end
  endtask

  task automatic test_two();
    req = 8'h81;
    tick();
    req = 8'h00;
    n_checks++; if (pending !== 8'h81) begin n_fail++; $display("FAIL two_pending got %h want 81", pending); end
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd7) begin n_fail++; $display("FAIL two_first got gv=%b idx=%0d want 1/7", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h01 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL two_dead got pend=%h gv=%b want 01/0", pending, grant_valid); end
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin n_fail++; $display("FAIL two_second got gv=%b idx=%0d want 1/0", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h00 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL two_done got pend=%h gv=%b want 00/0", pending, grant_valid); end
  endtask

  task automatic test_mask();
    mask_wr = 1'b1; mask_in = 8'h7F;
    tick();
    mask_wr = 1'b0;
    n_checks++; if (mask !== 8'h7F) begin n_fail++; $display("FAIL mask_write got %h want 7F", mask); end
    req = 8'h80;
    tick();
    req = 8'h00;
    tick(); tick();
    n_checks++; if (pending !== 8'h80 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL mask_block got pend=%h gv=%b want 80/0", pending, grant_valid); end
    mask_wr = 1'b1; mask_in = 8'hFF;
    tick();
    mask_wr = 1'b0;
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL mask_lag got gv=%b want 0", grant_valid); end
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd7) begin n_fail++; $display("FAIL mask_unblock got gv=%b idx=%0d want 1/7", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL mask_done got %h want 00", pending); end
  endtask

  task automatic test_no_preempt();
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    req = 8'h40;
    tick();
    req = 8'h00;
    n_checks++; if (pending !== 8'h48 || grant_idx !== 3'd3 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL preempt_hold got pend=%h gv=%b idx=%0d want 48/1/3", pending, grant_valid, grant_idx); end
    tick();
    n_checks++; if (grant_idx !== 3'd3 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL preempt_stable got gv=%b idx=%0d want 1/3", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h40 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL preempt_ack got pend=%h gv=%b want 40/0", pending, grant_valid); end
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd6) begin n_fail++; $display("FAIL preempt_next got gv=%b idx=%0d want 1/6", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
  endtask

  task automatic test_overflow();
    req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    req = 8'h20;
    tick();
    req = 8'h00;
    n_checks++; if (overflow !== 8'h20) begin n_fail++; $display("FAIL ovf_set got %h want 20", overflow); end
    tick();
    // Edge coincides with the ack of channel 5: set wins, no new overflow.
    req = 8'h20; grant_ack = 1'b1;
    tick();
    req = 8'h00; grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h20 || grant_valid !== 1'b0 || overflow !== 8'h20) begin n_fail++; $display("FAIL ovf_ack_edge got pend=%h gv=%b ovf=%h want 20/0/20", pending, grant_valid, overflow); end
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin n_fail++; $display("FAIL ovf_regrant got gv=%b idx=%0d want 1/5", grant_valid, grant_idx); end
    ovf_clr = 8'h20;
    tick();
    ovf_clr = 8'h00;
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL ovf_clr got %h want 00", overflow); end
    // Clear and a new overflow event in the same cycle: set wins.
    req = 8'h20; ovf_clr = 8'h20;
    tick();
    req = 8'h00;
    n_checks++; if (overflow !== 8'h20) begin n_fail++; $display("FAIL ovf_clr_vs_set got %h want 20", overflow); end
    tick();
    ovf_clr = 8'h00;
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL ovf_clr2 got %h want 00", overflow); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL ovf_done got %h want 00", pending); end
  endtask

  task automatic test_reset_mid_grant();
    mask_wr = 1'b1; mask_in = 8'h0F;
    tick();
    mask_wr = 1'b0;
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd1) begin n_fail++; $display("FAIL rst_pre got gv=%b idx=%0d want 1/1", grant_valid, grant_idx); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (grant_valid !== 1'b0 || grant_idx !== 3'd0 || pending !== 8'h00 || overflow !== 8'h00 || mask !== 8'hFF) begin n_fail++; $display("FAIL rst_mid got gv=%b idx=%0d pend=%h ovf=%h mask=%h want 0/0/00/00/FF", grant_valid, grant_idx, pending, overflow, mask); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    tick();
    n_checks++; if (grant_valid !== 1'b0 || pending !== 8'h00) begin n_fail++; $display("FAIL rst_ack_ignored got gv=%b pend=%h want 0/00", grant_valid, pending); end
    // A line held high through reset posts an edge right after release.
    req = 8'h10; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (pending !== 8'h10) begin n_fail++; $display("FAIL rst_held_req got %h want 10", pending); end
    req = 8'h00;
    tick();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd4) begin n_fail++; $display("FAIL rst_held_grant got gv=%b idx=%0d want 1/4", grant_valid, grant_idx); end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_mask();
    test_no_preempt();
    test_overflow();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
